// File: rtl/spi_master_ctrl_p_pkg.sv
// Shared definitions for the SPI master controller: register map, CTRL/FLAG
// bit layout and shift-engine state encoding.
package spi_pkg;

    localparam logic [7:0] ADDR_CTRL = 8'd4;
    localparam logic [7:0] ADDR_DATA = 8'd5;
    localparam logic [7:0] ADDR_FLAG = 8'd6;

    localparam int CTRL_CPOL    = 0;
    localparam int CTRL_CPHA    = 1;
    localparam int CTRL_CS_LSB  = 2;
    localparam int CTRL_CS_MSB  = 3;
    localparam int CTRL_DIV_LSB = 8;
    localparam int CTRL_DIV_MSB = 15;

    localparam int FLAG_BUSY = 0;
    localparam int FLAG_RXV  = 1;
    localparam int FLAG_OVR  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_TRAIL = 2'd3
    } spi_state_e;

endpackage

// File: rtl/spi_master_ctrl_p_if.sv
// Register-bus bundle of the SPI master controller (address, strobes, data, ready).
interface spi_master_ctrl_p_if;

    logic [7:0]  i_addr;
    logic        i_wen;
    logic        i_ren;
    logic [15:0] i_data;
    logic [15:0] o_rdata;
    logic        o_ready;

    modport master (
        output i_addr, i_wen, i_ren, i_data,
        input  o_rdata, o_ready
    );

    modport slave (
        input  i_addr, i_wen, i_ren, i_data,
        output o_rdata, o_ready
    );

endinterface

// File: rtl/spi_master_ctrl_p_shift_engine.sv
// SPI transfer engine: LEAD/SHIFT/TRAIL sequencing, SCLK generation, MSB-first
// TX/RX shift registers and chip-select drive.
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_tx,
    input  logic              i_cpol,
    input  logic              i_cpha,
    input  logic [1:0]        i_cs_idx,
    input  logic [7:0]        i_div,
    input  logic              i_miso,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_rx,
    output logic [NUM_CS-1:0] o_cs_n,
    output logic              o_sclk,
    output logic              o_mosi
);

    localparam int ECNT_W = $clog2(2 * DATA_W);
    localparam logic [ECNT_W-1:0] LAST_EDGE = ECNT_W'(2 * DATA_W - 1);

    spi_state_e        state_q, state_d;
    logic [7:0]        hcnt_q, hcnt_d;
    logic [ECNT_W-1:0] ecnt_q, ecnt_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic [NUM_CS-1:0] cs_n_q, cs_n_d;

    logic              period_end;
    logic              sample_edge;
    logic [DATA_W-1:0] tx_shl;
    logic [NUM_CS-1:0] cs_sel;

    // An out-of-range index leaves every select high; the transfer still runs.
    always_comb begin
        cs_sel = '1;
        for (int unsigned i = 0; i < NUM_CS; i++) begin
            if (32'(i_cs_idx) == i) cs_sel[i] = 1'b0;
        end
    end

    assign period_end  = (hcnt_q == i_div);
    assign sample_edge = (~ecnt_q[0]) ^ i_cpha;
    assign tx_shl      = tx_q << 1;

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        ecnt_d  = ecnt_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cs_n_d  = cs_n_q;
        unique case (state_q)
            ST_IDLE: begin
                sclk_d = i_cpol;
                mosi_d = 1'b0;
                cs_n_d = '1;
                hcnt_d = '0;
                ecnt_d = '0;
                if (i_start) begin
                    state_d = ST_LEAD;
                    tx_d    = i_tx;
                    mosi_d  = i_tx[DATA_W-1];
                    cs_n_d  = cs_sel;
                end
            end
            ST_LEAD: begin
                if (period_end) begin
                    hcnt_d  = '0;
                    state_d = ST_SHIFT;
                end else begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end
            ST_SHIFT: begin
                if (period_end) begin
                    hcnt_d = '0;
                    sclk_d = ~sclk_q;
                    ecnt_d = ecnt_q + 1'b1;
                    // Even edge counts are leading edges; CPHA picks sample vs. shift.
                    if (sample_edge) begin
                        rx_d = (rx_q << 1) | DATA_W'(i_miso);
                    end else if (i_cpha) begin
                        mosi_d = tx_q[DATA_W-1];
                        tx_d   = tx_shl;
                    end else begin
                        tx_d   = tx_shl;
                        mosi_d = tx_shl[DATA_W-1];
                    end
                    if (ecnt_q == LAST_EDGE) state_d = ST_TRAIL;
                end else begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end
            ST_TRAIL: begin
                if (period_end) begin
                    state_d = ST_IDLE;
                    hcnt_d  = '0;
                    cs_n_d  = '1;
                    mosi_d  = 1'b0;
                    sclk_d  = i_cpol;
                end else begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            hcnt_q  <= '0;
            ecnt_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= '1;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            ecnt_q  <= ecnt_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
        end
    end

    assign o_busy = (state_q != ST_IDLE);
    assign o_done = (state_q == ST_TRAIL) && period_end;
    assign o_rx   = rx_q;
    assign o_cs_n = cs_n_q;
    assign o_sclk = sclk_q;
    assign o_mosi = mosi_q;

endmodule

// File: rtl/spi_master_ctrl_p.sv
// SPI master controller top: CTRL/DATA/FLAG register decode, RX holding
// register and sticky flags around the shift engine.
module spi_master_ctrl_p
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    spi_master_ctrl_p_if.slave  bus,
    output logic [NUM_CS-1:0]   o_spi_cs_n,
    output logic                o_spi_clk,
    output logic                o_spi_mosi,
    input  logic                i_spi_miso
);

    logic              busy;
    logic              done;
    logic [DATA_W-1:0] eng_rx;

    logic wr_ctrl, wr_data, rd_data, rd_flag, start;

    logic        cpol_q, cpol_d;
    logic        cpha_q, cpha_d;
    logic [1:0]  cs_idx_q, cs_idx_d;
    logic [7:0]  div_q, div_d;
    logic [15:0] rx_q, rx_d;
    logic        rx_valid_q, rx_valid_d;
    logic        ovr_q, ovr_d;
    logic [15:0] ctrl_word;

    assign wr_ctrl   = bus.i_wen && (bus.i_addr == ADDR_CTRL);
    assign wr_data   = bus.i_wen && (bus.i_addr == ADDR_DATA);
    assign rd_data   = bus.i_ren && (bus.i_addr == ADDR_DATA);
    assign rd_flag   = bus.i_ren && (bus.i_addr == ADDR_FLAG);
    assign start     = wr_data && !busy;
    assign ctrl_word = {div_q, 4'b0000, cs_idx_q, cpha_q, cpol_q};

    // Clears are applied before sets so a coinciding set event wins.
    always_comb begin
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        cs_idx_d   = cs_idx_q;
        div_d      = div_q;
        rx_d       = rx_q;
        rx_valid_d = rx_valid_q;
        ovr_d      = ovr_q;
        if (wr_ctrl && !busy) begin
            cpol_d   = bus.i_data[CTRL_CPOL];
            cpha_d   = bus.i_data[CTRL_CPHA];
            cs_idx_d = bus.i_data[CTRL_CS_MSB:CTRL_CS_LSB];
            div_d    = bus.i_data[CTRL_DIV_MSB:CTRL_DIV_LSB];
        end
        if (rd_data) rx_valid_d = 1'b0;
        if (done) begin
            rx_d       = 16'(eng_rx);
            rx_valid_d = 1'b1;
        end
        if (rd_flag) ovr_d = 1'b0;
        if (wr_data && busy) ovr_d = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            cs_idx_q   <= '0;
            div_q      <= '0;
            rx_q       <= '0;
            rx_valid_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            cs_idx_q   <= cs_idx_d;
            div_q      <= div_d;
            rx_q       <= rx_d;
            rx_valid_q <= rx_valid_d;
            ovr_q      <= ovr_d;
        end
    end

    always_comb begin
        bus.o_rdata = '0;
        if (bus.i_ren) begin
            case (bus.i_addr)
                ADDR_CTRL: bus.o_rdata = ctrl_word;
                ADDR_DATA: bus.o_rdata = rx_q;
                ADDR_FLAG: bus.o_rdata = 16'({ovr_q, rx_valid_q, busy});
                default:   bus.o_rdata = '0;
            endcase
        end
    end

    assign bus.o_ready = !busy;

    spi_shift_engine #(
        .DATA_W(DATA_W),
        .NUM_CS(NUM_CS)
    ) u_engine (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (start),
        .i_tx     (bus.i_data[DATA_W-1:0]),
        .i_cpol   (cpol_q),
        .i_cpha   (cpha_q),
        .i_cs_idx (cs_idx_q),
        .i_div    (div_q),
        .i_miso   (i_spi_miso),
        .o_busy   (busy),
        .o_done   (done),
        .o_rx     (eng_rx),
        .o_cs_n   (o_spi_cs_n),
        .o_sclk   (o_spi_clk),
        .o_mosi   (o_spi_mosi)
    );

endmodule

// File: tb/tb_spi_master_ctrl_p.sv
// Bench for spi_master_ctrl_p: four parameterisations share one register bus,
// a selector picks which one is observed; RX results go through a scoreboard.
module tb_spi_master_ctrl_p;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  addr  = '0;
    logic        wen   = 1'b0;
    logic        ren   = 1'b0;
    logic [15:0] wdata = '0;
    logic        miso;
    int          sel   = 0;

    int n_run  = 0;
    int n_fail = 0;

    spi_master_ctrl_p_if bus0 ();
    spi_master_ctrl_p_if bus1 ();
    spi_master_ctrl_p_if bus2 ();
    spi_master_ctrl_p_if bus3 ();

    assign bus0.i_addr = addr;  assign bus0.i_wen = wen;  assign bus0.i_ren = ren;  assign bus0.i_data = wdata;
    assign bus1.i_addr = addr;  assign bus1.i_wen = wen;  assign bus1.i_ren = ren;  assign bus1.i_data = wdata;
    assign bus2.i_addr = addr;  assign bus2.i_wen = wen;  assign bus2.i_ren = ren;  assign bus2.i_data = wdata;
    assign bus3.i_addr = addr;  assign bus3.i_wen = wen;  assign bus3.i_ren = ren;  assign bus3.i_data = wdata;

    logic [0:0] cs0;
    logic [3:0] cs1;
    logic [1:0] cs2;
    logic [0:0] cs3;
    logic sclk0, sclk1, sclk2, sclk3;
    logic mosi0, mosi1, mosi2, mosi3;

    spi_master_ctrl_p #(.DATA_W(8), .NUM_CS(1)) dut0 (
        .i_clk(clk), .i_rst(rst), .bus(bus0),
        .o_spi_cs_n(cs0), .o_spi_clk(sclk0), .o_spi_mosi(mosi0), .i_spi_miso(miso));
    spi_master_ctrl_p #(.DATA_W(8), .NUM_CS(4)) dut1 (
        .i_clk(clk), .i_rst(rst), .bus(bus1),
        .o_spi_cs_n(cs1), .o_spi_clk(sclk1), .o_spi_mosi(mosi1), .i_spi_miso(miso));
    spi_master_ctrl_p #(.DATA_W(8), .NUM_CS(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .bus(bus2),
        .o_spi_cs_n(cs2), .o_spi_clk(sclk2), .o_spi_mosi(mosi2), .i_spi_miso(miso));
    spi_master_ctrl_p #(.DATA_W(12), .NUM_CS(1)) dut3 (
        .i_clk(clk), .i_rst(rst), .bus(bus3),
        .o_spi_cs_n(cs3), .o_spi_clk(sclk3), .o_spi_mosi(mosi3), .i_spi_miso(miso));

    logic [15:0] rdata_s;
    logic        ready_s, sclk_s, mosi_s, cs_act;
    logic [3:0]  cs_s;

    always_comb begin
        rdata_s = bus0.o_rdata; ready_s = bus0.o_ready; cs_s = {3'b111, cs0}; sclk_s = sclk0; mosi_s = mosi0;
        case (sel)
            1: begin rdata_s = bus1.o_rdata; ready_s = bus1.o_ready; cs_s = cs1;             sclk_s = sclk1; mosi_s = mosi1; end
            2: begin rdata_s = bus2.o_rdata; ready_s = bus2.o_ready; cs_s = {2'b11, cs2};    sclk_s = sclk2; mosi_s = mosi2; end
            3: begin rdata_s = bus3.o_rdata; ready_s = bus3.o_ready; cs_s = {3'b111, cs3};   sclk_s = sclk3; mosi_s = mosi3; end
            default: ;
        endcase
        cs_act = (cs_s != 4'hF);
    end

    // Slave side: either loop MOSI back, or serve slv_pat MSB-first per CPOL/CPHA.
    logic       loopback = 1'b1;
    logic       cpol_mon = 1'b0;
    logic       cpha_mon = 1'b0;
    logic [7:0] slv_pat  = 8'h3C;
    logic       slv_bit  = 1'b0;
    logic       slv_cs_prev = 1'b0;
    logic       slv_sclk_prev = 1'b0;
    int         slv_idx = 0;

    assign miso = loopback ? mosi_s : slv_bit;

    always @(negedge clk) begin
        slv_cs_prev   <= cs_act;
        slv_sclk_prev <= sclk_s;
        if (cs_act && !slv_cs_prev) begin
            if (cpha_mon) begin
                slv_idx <= 7;
            end else begin
                slv_bit <= slv_pat[7];
                slv_idx <= 6;
            end
        end else if (cs_act && (sclk_s !== slv_sclk_prev)) begin
            if (((slv_sclk_prev == cpol_mon) == cpha_mon) && slv_idx >= 0) begin
                slv_bit <= slv_pat[slv_idx[2:0]];
                slv_idx <= slv_idx - 1;
            end
        end
    end

    // Bus-side monitor: busy cycles, SCLK edge count/spacing, MOSI at leading edges.
    int          cyc = 0;
    logic        mon_clr = 1'b0;
    int          exp_gap = 1;
    int          busy_cnt = 0, edge_cnt = 0, gap_bad = 0, last_edge = -1;
    logic        prev_sclk = 1'b0;
    logic [15:0] mosi_bits = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_clr) begin
            busy_cnt  <= 0;
            edge_cnt  <= 0;
            gap_bad   <= 0;
            last_edge <= -1;
            mosi_bits <= '0;
            prev_sclk <= sclk_s;
        end else begin
            if (!ready_s) busy_cnt <= busy_cnt + 1;
            if (sclk_s !== prev_sclk) begin
                edge_cnt  <= edge_cnt + 1;
                last_edge <= cyc;
                if (last_edge >= 0 && (cyc - last_edge) != exp_gap) gap_bad <= gap_bad + 1;
                if (prev_sclk == cpol_mon && !cpha_mon) mosi_bits <= {mosi_bits[14:0], mosi_s};
            end
            prev_sclk <= sclk_s;
        end
    end

    logic [15:0] exp_q[$];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        addr = a; wdata = d; wen = 1'b1;
        tick(1);
        wen = 1'b0; addr = '0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [15:0] d);
        addr = a; ren = 1'b1;
        #1;
        d = rdata_s;
        tick(1);
        ren = 1'b0; addr = '0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [15:0] exp);
        logic [15:0] r;
        rd(a, r);
        chk(tag, 32'(r), 32'(exp));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic mon_clear();
        mon_clr = 1'b1;
        tick(1);
        mon_clr = 1'b0;
    endtask

    task automatic start_xfer(input logic [15:0] d, input logic [15:0] exp_rx);
        wr(ADDR_DATA, d);
        exp_q.push_back(exp_rx);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!ready_s && n < budget) begin
            tick(1);
            n++;
        end
        chk("idle_within_budget", 32'(ready_s), 32'd1);
    endtask

    task automatic check_rx(input string tag);
        logic [15:0] r, e;
        rd(ADDR_DATA, r);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 16'hDEAD;
        chk(tag, 32'(r), 32'(e));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic cp, ch;
        tick(2);
        do_reset();

        // Reset state
        sel = 0;
        chk("rst_ready", 32'(ready_s), 32'd1);
        chk("rst_cs_n", 32'(cs_s), 32'hF);
        chk("rst_sclk", 32'(sclk_s), 32'd0);
        chk("rst_mosi", 32'(mosi_s), 32'd0);
        rd_chk("rst_ctrl", ADDR_CTRL, 16'h0000);
        rd_chk("rst_flag", ADDR_FLAG, 16'h0000);
        rd_chk("unmapped_rd", 8'h07, 16'h0000);

        // Mode 0, DIV=0, loopback
        wr(ADDR_CTRL, 16'h0000);
        loopback = 1'b1; cpol_mon = 1'b0; cpha_mon = 1'b0; exp_gap = 1;
        mon_clear();
        start_xfer(16'h00A5, 16'h00A5);
        wait_idle(200);
        chk("m0_busy_cycles", 32'(busy_cnt), 32'd18);
        chk("m0_edges", 32'(edge_cnt), 32'd16);
        chk("m0_gap", 32'(gap_bad), 32'd0);
        chk("m0_mosi_seq", 32'(mosi_bits[7:0]), 32'hA5);
        rd_chk("m0_flag", ADDR_FLAG, 16'h0002);
        addr = ADDR_FLAG; ren = 1'b0; #1;
        chk("rdata_ren_low", 32'(rdata_s), 32'd0);
        tick(1);
        check_rx("m0_rx");
        rd_chk("m0_flag_after_rd", ADDR_FLAG, 16'h0000);

        // Modes 1..3, DIV=3, slave returns 0x3C
        loopback = 1'b0; slv_pat = 8'h3C; exp_gap = 4;
        for (int m = 1; m < 4; m++) begin
            cp = (m >= 2);
            ch = (m == 1 || m == 3);
            cpol_mon = cp; cpha_mon = ch;
            wr(ADDR_CTRL, 16'h0300 | {14'b0, ch, cp});
            tick(2);
            chk("mode_sclk_idle", 32'(sclk_s), 32'(cp));
            mon_clear();
            start_xfer(16'h00C3, 16'h003C);
            wait_idle(400);
            chk("mode_edges", 32'(edge_cnt), 32'd16);
            chk("mode_gap", 32'(gap_bad), 32'd0);
            chk("mode_busy_cycles", 32'(busy_cnt), 32'd72);
            chk("mode_sclk_after", 32'(sclk_s), 32'(cp));
            check_rx("mode_rx");
        end

        // Overrun and CTRL write while busy
        do_reset();
        sel = 0; loopback = 1'b1; cpol_mon = 1'b0; cpha_mon = 1'b0; exp_gap = 1;
        wr(ADDR_CTRL, 16'h0000);
        start_xfer(16'h0011, 16'h0011);
        tick(3);
        wr(ADDR_DATA, 16'h0022);
        rd_chk("ovr_flag_set", ADDR_FLAG, 16'h0005);
        rd_chk("ovr_flag_cleared", ADDR_FLAG, 16'h0001);
        wr(ADDR_CTRL, 16'hFF03);
        wait_idle(200);
        rd_chk("ctrl_unchanged", ADDR_CTRL, 16'h0000);
        check_rx("ovr_rx_first_only");
        rd_chk("ovr_flag_final", ADDR_FLAG, 16'h0000);

        // Reset mid-transfer
        wr(ADDR_CTRL, 16'h0101);
        tick(1);
        wr(ADDR_DATA, 16'h005A);
        tick(6);
        chk("pre_rst_busy", 32'(ready_s), 32'd0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("midrst_cs_n", 32'(cs_s), 32'hF);
        chk("midrst_sclk", 32'(sclk_s), 32'd0);
        chk("midrst_mosi", 32'(mosi_s), 32'd0);
        chk("midrst_ready", 32'(ready_s), 32'd1);
        rd_chk("midrst_flag", ADDR_FLAG, 16'h0000);
        rd_chk("midrst_ctrl", ADDR_CTRL, 16'h0000);
        tick(40);
        rd_chk("midrst_no_rxv", ADDR_FLAG, 16'h0000);
        rd_chk("midrst_rx", ADDR_DATA, 16'h0000);

        // CS index 2 on NUM_CS=4
        do_reset();
        sel = 1;
        wr(ADDR_CTRL, 16'h0008);
        mon_clear();
        start_xfer(16'h0069, 16'h0069);
        tick(2);
        chk("cs2_of4", 32'(cs_s), 32'hB);
        wait_idle(200);
        chk("cs2_busy_cycles", 32'(busy_cnt), 32'd18);
        chk("cs2_released", 32'(cs_s), 32'hF);
        check_rx("cs2_rx");

        // CS index 3 on NUM_CS=2: no select, transfer still runs
        do_reset();
        sel = 2;
        wr(ADDR_CTRL, 16'h000C);
        mon_clear();
        start_xfer(16'h0096, 16'h0096);
        tick(2);
        chk("cs3_of2_none", 32'(cs_s), 32'hF);
        chk("cs3_of2_busy", 32'(ready_s), 32'd0);
        wait_idle(200);
        chk("cs3_busy_cycles", 32'(busy_cnt), 32'd18);
        check_rx("cs3_rx");

        // DATA_W=12, DIV=1
        do_reset();
        sel = 3; exp_gap = 2; cpol_mon = 1'b0; cpha_mon = 1'b0;
        wr(ADDR_CTRL, 16'h0100);
        mon_clear();
        start_xfer(16'hFABC, 16'h0ABC);
        wait_idle(300);
        chk("w12_busy_cycles", 32'(busy_cnt), 32'd52);
        chk("w12_edges", 32'(edge_cnt), 32'd24);
        chk("w12_gap", 32'(gap_bad), 32'd0);
        chk("w12_mosi_seq", 32'(mosi_bits[11:0]), 32'hABC);
        check_rx("w12_rx");
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
